// File: rtl/adc_capture_buffer_if.sv
// adc_capture_buffer_if
//
// Stream bundle for the ADC capture buffer: the parallel ADC word input
// and the sample-by-sample valid/ready readout.
//
// Parameters:
//   LANES     samples per input word
//   SAMPLE_W  bits per sample
//
// Signals:
//   in_valid   in_data word valid
//   in_data    LANES*SAMPLE_W parallel samples, lane 0 in the low bits
//   out_valid  out_data valid
//   out_ready  downstream accept
//   out_data   one sample
//   out_last   final sample of a capture
//
// Modports:
//   master  the capture buffer (consumes in_*, produces out_*)
//   slave   the surrounding logic (produces in_*, consumes out_*)

interface adc_capture_buffer_if #(
    parameter int LANES    = 96,
    parameter int SAMPLE_W = 9
);
    logic                      in_valid;
    logic [LANES*SAMPLE_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SAMPLE_W-1:0]       out_data;
    logic                      out_last;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
//
// Capture-side consumer of the time-interleaved ADC sample bus. Arms on
// request, waits for a trigger, discards skip_len words, stores DEPTH
// words, then drains them one sample at a time (word 0..DEPTH-1, lane
// 0..LANES-1) over a valid/ready stream.
//
// Optional build macro:
//   ADC_CAP_TWOS_COMP_EN  when defined, out_data has its MSB inverted
//                         (offset binary -> two's complement). Stored
//                         buffer contents are unaffected.
//
// Ports:
//   clk       capture clock (ADC word clock)
//   reset     asynchronous, active-high reset
//   arm       start request, honoured only in IDLE
//   abort     return to IDLE from any state, wins over arm
//   trig      trigger level, honoured only in ARMED
//   skip_len  words discarded after the trigger, latched on the trigger cycle
//   bus       in_valid/in_data input words, out_* sample stream
//   busy      state != IDLE
//   done      one-cycle pulse after the final sample transfers
//   state     IDLE=0, ARMED=1, SKIP=2, FILL=3, READ=4
//
// State | Meaning
// IDLE  | waiting for arm
// ARMED | waiting for trig
// SKIP  | discarding words until skip_cnt reaches skip_len
// FILL  | writing valid words into buffer[wr_ptr]
// READ  | streaming samples out

module adc_capture_buffer #(
    parameter int LANES    = 96,
    parameter int SAMPLE_W = 9,
    parameter int DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig,
    input  logic [15:0]            skip_len,
    adc_capture_buffer_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state
);

    localparam int WORD_BITS = LANES * SAMPLE_W;
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORD_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
    localparam logic [WORD_W-1:0] WORD_MAX = WORD_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_SKIP  = 3'd2,
        S_FILL  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t                state_q, state_d;

    logic [15:0]           skip_len_q;
    logic [15:0]           skip_cnt_q;
    logic [WORD_W-1:0]     wr_ptr_q;
    logic [WORD_W-1:0]     rd_word_q;
    logic [LANE_W-1:0]     rd_lane_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [SAMPLE_W-1:0]   out_data_q;
    logic                  done_q;

    logic [WORD_BITS-1:0]  mem [DEPTH];

    // Control strobes from the next-state logic into the datapath.
    logic                  buf_we;
    logic                  skip_ld;
    logic                  skip_inc;
    logic                  rd_start;
    logic                  rd_adv;
    logic                  finish;
    logic                  clr;

    logic [WORD_W-1:0]     next_word;
    logic [LANE_W-1:0]     next_lane;
    logic [WORD_W-1:0]     rd_sel_word;
    logic [LANE_W-1:0]     rd_sel_lane;
    logic [WORD_BITS-1:0]  word_sel;
    logic [SAMPLE_W-1:0]   sample_sel;
    logic [SAMPLE_W-1:0]   sample_out;
    logic                  last_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_we   = 1'b0;
        skip_ld  = 1'b0;
        skip_inc = 1'b0;
        rd_start = 1'b0;
        rd_adv   = 1'b0;
        finish   = 1'b0;
        clr      = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig) begin
                        skip_ld = 1'b1;
                        if (skip_len == 16'd0) begin
                            // Trigger word lands at buffer word 0 when valid.
                            state_d = S_FILL;
                            buf_we  = bus.in_valid;
                        end else if (skip_len == 16'd1 && bus.in_valid) begin
                            // Trigger word was the only word to discard.
                            state_d = S_FILL;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end
                end
                S_SKIP: begin
                    if (bus.in_valid) begin
                        skip_inc = 1'b1;
                        if (skip_cnt_q + 16'd1 == skip_len_q) begin
                            state_d = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.in_valid) begin
                        buf_we = 1'b1;
                        if (wr_ptr_q == WORD_MAX) begin
                            state_d  = S_READ;
                            rd_start = 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            state_d = S_IDLE;
                            finish  = 1'b1;
                        end else begin
                            rd_adv = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Read address of the sample that the output register loads next.
    always_comb begin
        next_word = rd_word_q;
        next_lane = rd_lane_q + 1'b1;
        if (rd_lane_q == LANE_MAX) begin
            next_lane = '0;
            next_word = rd_word_q + 1'b1;
        end
        rd_sel_word = rd_start ? '0 : next_word;
        rd_sel_lane = rd_start ? '0 : next_lane;
        last_sel    = (rd_sel_word == WORD_MAX) && (rd_sel_lane == LANE_MAX);
    end

    always_comb begin
        word_sel   = mem[rd_sel_word];
        sample_sel = word_sel[int'(rd_sel_lane) * SAMPLE_W +: SAMPLE_W];
`ifdef ADC_CAP_TWOS_COMP_EN
        sample_out = {~sample_sel[SAMPLE_W-1], sample_sel[SAMPLE_W-2:0]};
`else
        sample_out = sample_sel;
`endif
    end

    // Buffer storage carries no reset; its contents are only read after a
    // complete fill.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_len_q  <= '0;
            skip_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_word_q   <= '0;
            rd_lane_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= finish;
            if (clr || finish) begin
                skip_len_q  <= '0;
                skip_cnt_q  <= '0;
                wr_ptr_q    <= '0;
                rd_word_q   <= '0;
                rd_lane_q   <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_data_q  <= '0;
            end else begin
                if (skip_ld) begin
                    skip_len_q <= skip_len;
                    skip_cnt_q <= (bus.in_valid && skip_len != 16'd0) ? 16'd1 : 16'd0;
                end
                if (skip_inc) begin
                    skip_cnt_q <= skip_cnt_q + 16'd1;
                end
                if (buf_we) begin
                    // Wraps back to 0 on the final write since DEPTH is a power of 2.
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (rd_start || rd_adv) begin
                    rd_word_q   <= rd_sel_word;
                    rd_lane_q   <= rd_sel_lane;
                    out_valid_q <= 1'b1;
                    out_last_q  <= last_sel;
                    out_data_q  <= sample_out;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign state         = state_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;

    localparam int LANES    = 4;
    localparam int SAMPLE_W = 9;
    localparam int DEPTH    = 4;
    localparam int TOTAL    = LANES * DEPTH;
    localparam int WB       = LANES * SAMPLE_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        abort;
    logic        trig;
    logic [15:0] skip_len;
    logic        busy;
    logic        done;
    logic [2:0]  state;

    adc_capture_buffer_if #(.LANES(LANES), .SAMPLE_W(SAMPLE_W)) bus ();

    adc_capture_buffer #(
        .LANES   (LANES),
        .SAMPLE_W(SAMPLE_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .arm     (arm),
        .abort   (abort),
        .trig    (trig),
        .skip_len(skip_len),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Every valid word presented from the trigger cycle onward.
    logic [WB-1:0] vq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] make_word(input int n, input int dmode);
        logic [WB-1:0]       w;
        logic [SAMPLE_W-1:0] tbl [4];
        tbl[0] = 9'h1FF;
        tbl[1] = 9'h000;
        tbl[2] = 9'h100;
        tbl[3] = 9'h0FF;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            case (dmode)
                0:       w[l*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(LANES * n + l);
                2:       w[l*SAMPLE_W +: SAMPLE_W] = tbl[(n + l) % 4];
                default: w[l*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
            endcase
        end
        return w;
    endfunction

    function automatic logic [WB-1:0] garbage();
        return WB'({$urandom, $urandom});
    endfunction

    // k-th streamed sample: word (skip + k/LANES) of the valid words seen
    // since the trigger, lane k%LANES.
    function automatic logic [SAMPLE_W-1:0] exp_sample(input int k, input int skip);
        logic [WB-1:0]       w;
        logic [SAMPLE_W-1:0] s;
        w = vq[skip + k / LANES];
        s = SAMPLE_W'(w >> ((k % LANES) * SAMPLE_W));
`ifdef ADC_CAP_TWOS_COMP_EN
        s = s ^ 9'h100;
`endif
        return s;
    endfunction

    task automatic capture(input int skip, input int vmode, input int dmode,
                           input bit rand_ready, input bit poke);
        int  n;
        int  cyc;
        int  k;
        bit  v;
        bit  r;
        vq.delete();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("armed_state", state, 3'd1);
        check("armed_busy", busy, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_data  = garbage();
        @(negedge clk);
        check("armed_wait", state, 3'd1);

        trig         = 1'b1;
        skip_len     = 16'(skip);
        bus.in_valid = 1'b1;
        bus.in_data  = make_word(0, dmode);
        vq.push_back(bus.in_data);
        n = 1;
        @(negedge clk);
        trig     = 1'b0;
        skip_len = 16'($urandom);

        cyc = 0;
        while (state != 3'd4 && cyc < 200) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = 1'($urandom % 2);
            endcase
            bus.in_valid = v;
            if (v) begin
                bus.in_data = make_word(n, dmode);
                vq.push_back(bus.in_data);
                n++;
            end else begin
                bus.in_data = garbage();
            end
            @(negedge clk);
            cyc++;
        end
        check("reach_read", state, 3'd4);
        check("words_consumed", vq.size(), skip + DEPTH);

        k   = 0;
        cyc = 0;
        while (k < TOTAL && cyc < 400) begin
            check("rd_valid", bus.out_valid, 1'b1);
            check("rd_data", bus.out_data, exp_sample(k, skip));
            check("rd_last", bus.out_last, (k == TOTAL - 1));
            check("rd_state", state, 3'd4);
            bus.in_valid = 1'b1;
            bus.in_data  = garbage();
            r = rand_ready ? 1'($urandom % 2) : 1'b1;
            bus.out_ready = r;
            if (poke) begin
                arm  = 1'($urandom % 2);
                trig = 1'($urandom % 2);
            end
            if (r) k++;
            @(negedge clk);
            cyc++;
        end
        check("transfer_count", k, TOTAL);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        arm  = 1'b0;
        trig = 1'b0;
        check("end_valid", bus.out_valid, 1'b0);
        check("end_last", bus.out_last, 1'b0);
        check("end_done", done, 1'b1);
        check("end_state", state, 3'd0);
        check("end_busy", busy, 1'b0);
        @(negedge clk);
        check("done_pulse_width", done, 1'b0);
        check("stay_idle", state, 3'd0);
    endtask

    initial begin
        reset         = 1'b1;
        arm           = 1'b0;
        abort         = 1'b0;
        trig          = 1'b0;
        skip_len      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", bus.out_data, '0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", state, 3'd0);

        capture(0, 0, 0, 1'b0, 1'b0);
        capture(3, 0, 0, 1'b0, 1'b0);
        capture(1, 1, 0, 1'b1, 1'b0);

        trig         = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("trig_in_idle", state, 3'd0);
        end
        trig         = 1'b0;
        bus.in_valid = 1'b0;
        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_state", state, 3'd0);
        check("arm_abort_busy", busy, 1'b0);

        capture(2, 2, 1, 1'b1, 1'b1);

        arm = 1'b1;
        @(negedge clk);
        arm          = 1'b0;
        trig         = 1'b1;
        skip_len     = 16'd0;
        bus.in_valid = 1'b1;
        bus.in_data  = make_word(0, 1);
        @(negedge clk);
        trig        = 1'b0;
        bus.in_data = make_word(1, 1);
        @(negedge clk);
        check("abort_pre_state", state, 3'd3);
        abort       = 1'b1;
        bus.in_data = make_word(2, 1);
        @(negedge clk);
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_state", state, 3'd0);
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        check("abort_no_done", done, 1'b0);

        capture(5, 2, 1, 1'b1, 1'b1);

        arm = 1'b1;
        @(negedge clk);
        arm          = 1'b0;
        trig         = 1'b1;
        skip_len     = 16'd0;
        bus.in_valid = 1'b1;
        bus.in_data  = make_word(0, 1);
        @(negedge clk);
        trig = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", state, 3'd0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_valid", bus.out_valid, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("async_rst_idle", state, 3'd0);

        capture(0, 0, 2, 1'b0, 1'b0);
        capture(1, 2, 2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
